cache_flush_sequencer: RTL and testbench

- Sequences a full-cache flush/sweep by issuing one line-sized read request per (set, way) slot to the cache backend port.
- Throttles the number of outstanding requests, then signals completion once every response has returned.
- Sits between the kernel control path and the cache request mux. The kernel pulses start at the end of a graph pass, and the sequencer owns the cache port until done.

---
 rtl/cache_flush_sequencer_if.sv | 35 +++
 rtl/cache_flush_sequencer.sv | 150 +++++++++++++++
 tb/tb_cache_flush_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_flush_sequencer_if.sv
// Signal bundle between the flush sequencer, the kernel control path and the cache request port.
// perf_cycles_out is present only when CACHE_FLUSH_PERF_EN is defined.
interface cache_flush_sequencer_if #(
  parameter int ADDR_W = 64
);
  logic              start_in;
  logic [ADDR_W-1:0] base_addr_in;
  logic              req_valid_out;
  logic [ADDR_W-1:0] req_addr_out;
  logic              req_ready_in;
  logic              resp_valid_in;
  logic              busy_out;
  logic              done_out;
  logic              err_out;
`ifdef CACHE_FLUSH_PERF_EN
  logic [31:0]       perf_cycles_out;
`endif

  // The sequencer is the master of the cache request port.
  modport master (
    input  start_in, base_addr_in, req_ready_in, resp_valid_in,
    output req_valid_out, req_addr_out, busy_out, done_out, err_out
`ifdef CACHE_FLUSH_PERF_EN
    , output perf_cycles_out
`endif
  );

  modport slave (
    output start_in, base_addr_in, req_ready_in, resp_valid_in,
    input  req_valid_out, req_addr_out, busy_out, done_out, err_out
`ifdef CACHE_FLUSH_PERF_EN
    , input perf_cycles_out
`endif
  );
endinterface

// File: rtl/cache_flush_sequencer.sv
// Sweeps every (set, way) slot of the cache with throttled line reads, then pulses done.
// Optional busy-cycle counter (perf_cycles_out) is enabled by defining CACHE_FLUSH_PERF_EN.
module cache_flush_sequencer #(
  parameter int ADDR_W          = 64,
  parameter int NUM_WAYS        = 4,
  parameter int LINE_BYTES      = 64,
  parameter int CACHE_BYTES     = 32768,
  parameter int MAX_OUTSTANDING = 16
) (
  input logic                     ap_clk,
  input logic                     ap_rst_n,
  cache_flush_sequencer_if.master bus
);

  localparam int LINE_LOG = $clog2(LINE_BYTES);
  localparam int WAY_LOG  = $clog2(NUM_WAYS);
  localparam int NUM_SETS = CACHE_BYTES >> (LINE_LOG + WAY_LOG);
  localparam int COUNT    = NUM_SETS * NUM_WAYS;
  localparam int CNT_W    = $clog2(COUNT + 1);
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(COUNT - 1);
  localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issueCnt_q, issueCnt_d;
  logic [OUT_W-1:0]  outCnt_q, outCnt_d;
  logic [ADDR_W-1:0] baseAddr_q, baseAddr_d;
  logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
  logic              reqValid_q, reqValid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              fire;
  logic              startAcc;
  logic              respOk;
  logic [CNT_W-1:0]  issueNext;

  // Set index lands above the way bits, way index lands above the line offset.
  function automatic logic [ADDR_W-1:0] slotOffset(input logic [CNT_W-1:0] slot);
    logic [ADDR_W-1:0] s;
    s = ADDR_W'(slot);
    return ((s >> WAY_LOG) << (LINE_LOG + WAY_LOG)) |
           ((s & ADDR_W'(NUM_WAYS - 1)) << LINE_LOG);
  endfunction

  assign fire      = reqValid_q && bus.req_ready_in;
  assign startAcc  = (state_q == IDLE) && bus.start_in;
  assign respOk    = bus.resp_valid_in && (outCnt_q != '0);
  assign issueNext = issueCnt_q + CNT_W'(1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      issueCnt_q <= '0;
      outCnt_q   <= '0;
      baseAddr_q <= '0;
      reqAddr_q  <= '0;
      reqValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      issueCnt_q <= issueCnt_d;
      outCnt_q   <= outCnt_d;
      baseAddr_q <= baseAddr_d;
      reqAddr_q  <= reqAddr_d;
      reqValid_q <= reqValid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // DRAIN tests the registered count, which already includes a response that arrived on entry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_in) state_d = ISSUE;
      ISSUE:   if (fire && (issueCnt_q == LAST_SLOT)) state_d = DRAIN;
      DRAIN:   if (outCnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issueCnt_d = issueCnt_q;
    baseAddr_d = baseAddr_q;
    reqAddr_d  = reqAddr_q;
    outCnt_d   = outCnt_q;
    err_d      = err_q;

    if (startAcc) begin
      baseAddr_d = bus.base_addr_in;
      reqAddr_d  = bus.base_addr_in;
      issueCnt_d = '0;
      err_d      = 1'b0;
    end else if (fire) begin
      issueCnt_d = issueNext;
      reqAddr_d  = baseAddr_q + slotOffset(issueNext);
    end

    unique case ({fire, respOk})
      2'b10:   outCnt_d = outCnt_q + OUT_W'(1);
      2'b01:   outCnt_d = outCnt_q - OUT_W'(1);
      default: outCnt_d = outCnt_q;
    endcase

    // A stray response also covers ones still in flight across a reset.
    if (bus.resp_valid_in && (outCnt_q == '0)) err_d = 1'b1;

    reqValid_d = (state_d == ISSUE) && (outCnt_d < MAX_OUT);
    busy_d     = (state_d == ISSUE) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  assign bus.req_valid_out = reqValid_q;
  assign bus.req_addr_out  = reqAddr_q;
  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.err_out       = err_q;

`ifdef CACHE_FLUSH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (startAcc) perf_d = '0;
    else if (busy_q && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) perf_q <= '0;
    else           perf_q <= perf_d;
  end

  assign bus.perf_cycles_out = perf_q;
`endif

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// Scoreboard bench for cache_flush_sequencer: expected line addresses are queued per accepted start
// and a negedge monitor checks fires, throttling, stalls and completion against a slot/outstanding model.
module tb_cache_flush_sequencer;
  localparam int ADDR_W      = 64;
  localparam int NUM_WAYS    = 4;
  localparam int LINE_BYTES  = 64;
  localparam int CACHE_BYTES = 1024;
  localparam int MAX_OUT     = 2;
  localparam int SLOTS       = CACHE_BYTES / LINE_BYTES;
  localparam int RESP_DELAY  = 3;

  logic ap_clk = 1'b0;
  logic ap_rst_n;

  cache_flush_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  cache_flush_sequencer #(
    .ADDR_W(ADDR_W), .NUM_WAYS(NUM_WAYS), .LINE_BYTES(LINE_BYTES),
    .CACHE_BYTES(CACHE_BYTES), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus(bus)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  logic [ADDR_W-1:0] expAddrQ[$];
  int dueQ[$];
  int modelOut = 0;
  int fireCount = 0;
  int doneCount = 0;
  int lastRespCycle = 0;
  int startCycle = 0;
  int perfExpected = 0;
  int respBudget = -1;
  int manualReq = 0;
  bit randomReady = 1'b0;
  bit monFire;
  bit respCounts;
  bit prevValid = 1'b0;
  bit prevFire = 1'b0;
  logic [ADDR_W-1:0] prevAddr = '0;
  int f0;
  int d0;
  int n;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Caller sits just after a rising edge; start is held for exactly one cycle.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input bit accepted);
    bus.start_in     = 1'b1;
    bus.base_addr_in = base;
    @(posedge ap_clk); #1;
    bus.start_in = 1'b0;
    if (accepted) begin
      startCycle = cycle;
      for (int i = 0; i < SLOTS; i++)
        expAddrQ.push_back(base + ADDR_W'(i) * ADDR_W'(LINE_BYTES));
    end
  endtask

  task automatic waitDone(input int budget);
    int target = doneCount + 1;
    int k = 0;
    while (doneCount < target && k < budget) begin
      @(posedge ap_clk); #1;
      k++;
    end
    checkOutput("done_seen", 64'(doneCount), 64'(target));
  endtask

  // Backend model: ready pattern plus responses RESP_DELAY cycles after each fire.
  always @(posedge ap_clk) begin
    cycle = cycle + 1;
    #1;
    bus.req_ready_in  = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.resp_valid_in = 1'b0;
    if (manualReq > 0) begin
      bus.resp_valid_in = 1'b1;
      manualReq--;
    end else if (respBudget != 0 && dueQ.size() > 0 && dueQ[0] <= cycle) begin
      void'(dueQ.pop_front());
      bus.resp_valid_in = 1'b1;
      if (respBudget > 0) respBudget--;
    end
  end

  // Monitor: valid must equal "slots left and in-flight below the limit".
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prevValid = 1'b0;
      prevFire  = 1'b0;
    end else begin
      monFire = bus.req_valid_out && bus.req_ready_in;
      checkOutput("req_valid", 64'(bus.req_valid_out),
                  64'((expAddrQ.size() > 0) && (modelOut < MAX_OUT)));
      if (prevValid && !prevFire) begin
        checkOutput("stall_valid", 64'(bus.req_valid_out), 64'(1));
        checkOutput("stall_addr", bus.req_addr_out, prevAddr);
      end
      if (monFire) begin
        fireCount++;
        if (expAddrQ.size() > 0) checkOutput("fire_addr", bus.req_addr_out, expAddrQ.pop_front());
        dueQ.push_back(cycle + RESP_DELAY);
      end
      respCounts = bus.resp_valid_in && (modelOut > 0);
      if (respCounts) lastRespCycle = cycle;
      modelOut = modelOut + (monFire ? 1 : 0) - (respCounts ? 1 : 0);
      if (bus.done_out) begin
        doneCount++;
        checkOutput("done_all_retired", 64'(expAddrQ.size() + modelOut), 64'(0));
        checkOutput("done_latency", 64'(cycle - lastRespCycle), 64'(2));
        checkOutput("busy_at_done", 64'(bus.busy_out), 64'(0));
`ifdef CACHE_FLUSH_PERF_EN
        perfExpected = cycle - startCycle;
        checkOutput("perf_cycles", 64'(bus.perf_cycles_out), 64'(perfExpected));
`endif
      end
      prevValid = bus.req_valid_out;
      prevFire  = monFire;
      prevAddr  = bus.req_addr_out;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ap_rst_n         = 1'b0;
    bus.start_in     = 1'b0;
    bus.base_addr_in = '0;
    @(posedge ap_clk); #1;
    checkOutput("rst_valid", 64'(bus.req_valid_out), 64'(0));
    checkOutput("rst_addr", bus.req_addr_out, 64'(0));
    checkOutput("rst_busy", 64'(bus.busy_out), 64'(0));
    checkOutput("rst_done", 64'(bus.done_out), 64'(0));
    checkOutput("rst_err", 64'(bus.err_out), 64'(0));
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    $display("[TB] full sweep, ready held high, ignored restart while busy");
    f0 = fireCount; d0 = doneCount;
    applyStimulus(64'h1000, 1'b1);
    checkOutput("busy_after_start", 64'(bus.busy_out), 64'(1));
    checkOutput("first_valid", 64'(bus.req_valid_out), 64'(1));
    checkOutput("first_addr", bus.req_addr_out, 64'h1000);
    repeat (5) begin @(posedge ap_clk); #1; end
    applyStimulus(64'h9000, 1'b0);
    waitDone(300);
    checkOutput("fires_total", 64'(fireCount - f0), 64'(SLOTS));
    checkOutput("err_clean", 64'(bus.err_out), 64'(0));
    repeat (3) begin @(posedge ap_clk); #1; end
    checkOutput("done_once", 64'(doneCount - d0), 64'(1));
`ifdef CACHE_FLUSH_PERF_EN
    checkOutput("perf_frozen", 64'(bus.perf_cycles_out), 64'(perfExpected));
`endif

    $display("[TB] throttle at the outstanding limit");
    respBudget = 0;
    f0 = fireCount;
    applyStimulus(64'h1000, 1'b1);
    repeat (6) begin @(posedge ap_clk); #1; end
    checkOutput("throttle_fires", 64'(fireCount - f0), 64'(MAX_OUT));
    checkOutput("throttle_valid", 64'(bus.req_valid_out), 64'(0));
    @(negedge ap_clk);
    respBudget = 1;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    checkOutput("reassert_valid", 64'(bus.req_valid_out), 64'(1));
    checkOutput("reassert_addr", bus.req_addr_out, 64'h1080);
    respBudget = -1;
    waitDone(300);
    checkOutput("throttle_total", 64'(fireCount - f0), 64'(SLOTS));

    $display("[TB] random ready back-pressure");
    randomReady = 1'b1;
    f0 = fireCount;
    applyStimulus(64'h2000, 1'b1);
    waitDone(800);
    checkOutput("random_total", 64'(fireCount - f0), 64'(SLOTS));
    randomReady = 1'b0;
    @(posedge ap_clk); #1;

    $display("[TB] stray response while idle");
    @(negedge ap_clk);
    manualReq = 1;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    checkOutput("stray_err_set", 64'(bus.err_out), 64'(1));
    applyStimulus(64'h3000, 1'b1);
    checkOutput("err_cleared", 64'(bus.err_out), 64'(0));
    waitDone(300);

    $display("[TB] reset after the fifth fire");
    f0 = fireCount;
    applyStimulus(64'h4000, 1'b1);
    n = 0;
    while (fireCount - f0 < 5 && n < 100) begin
      @(negedge ap_clk); #1;
      n++;
    end
    checkOutput("fires_before_reset", 64'(fireCount - f0), 64'(5));
    ap_rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 64'(bus.req_valid_out), 64'(0));
    checkOutput("async_addr", bus.req_addr_out, 64'(0));
    checkOutput("async_busy", 64'(bus.busy_out), 64'(0));
    checkOutput("async_done", 64'(bus.done_out), 64'(0));
    checkOutput("async_err", 64'(bus.err_out), 64'(0));
    expAddrQ.delete();
    dueQ.delete();
    modelOut = 0;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    applyStimulus(64'h4000, 1'b1);
    checkOutput("restart_addr", bus.req_addr_out, 64'h4000);
    waitDone(300);

    $display("[TB] address wrap at the top of the space");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFC0, 1'b1);
    @(posedge ap_clk); #1;
    checkOutput("wrap_addr", bus.req_addr_out, 64'h0);
    waitDone(300);
    repeat (3) begin @(posedge ap_clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
